// File: rtl/jogo_pkg.sv
// Shared definitions for the parametrised memory-sequence game.
package jogo_pkg;

    // State codes double as the db_estado display value.
    typedef enum logic [3:0] {
        StInicial      = 4'h0,
        StPreparacao   = 4'h1,
        StMostraLed    = 4'h2,
        StApagaLed     = 4'h3,
        StEsperaJogada = 4'h4,
        StRegistra     = 4'h5,
        StCompara      = 4'h6,
        StUltimaRodada = 4'h7,
        StFimAcerto    = 4'hC,
        StFimTimeout   = 4'hD,
        StFimErro      = 4'hE
    } estado_t;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3.
    localparam int unsigned LfsrWidth = 8;
    localparam logic [LfsrWidth-1:0] LfsrTaps = 8'b1011_1000;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] idx_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != '0) && ((v & (v - 8'd1)) == '0);
    endfunction

endpackage

// File: rtl/contador_param.sv
// Saturating up-counter with synchronous clear.
module contador_param #(
    parameter int unsigned Largura = 4,
    parameter int unsigned Maximo  = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               zera,
    input  logic               conta,
    output logic [Largura-1:0] q
);

    localparam logic [Largura-1:0] Fim = Largura'(Maximo);

    // Clear wins over count; hold at the terminal value instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            q <= '0;
        end else if (conta && (q != Fim)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/fluxo_dados_param.sv
// Game datapath: LFSR, sequence memory, counters, jogada capture and compare.
module fluxo_dados_param
    import jogo_pkg::*;
#(
    parameter int unsigned N_BOTOES       = 4,
    parameter int unsigned N_RODADAS      = 16,
    parameter int unsigned TIMEOUT_CICLOS = 3000,
    parameter int unsigned T_LED          = 1000,
    parameter logic [7:0]  SEMENTE        = 8'hA5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                grava_mem,
    input  logic                zera_rodada,
    input  logic                conta_rodada,
    input  logic                zera_contagem,
    input  logic                conta_contagem,
    input  logic                zera_timer,
    input  logic                conta_timer,
    input  logic                zera_timeout,
    input  logic                conta_timeout,
    input  logic                grava_jogada,
    input  logic                mostra,
    output logic                jogada_edge,
    output logic                igual,
    output logic                contagem_eq_rodada,
    output logic                ultima_rodada,
    output logic                fim_prep,
    output logic                fim_led,
    output logic                fim_timeout,
    output logic [N_BOTOES-1:0] leds,
    output logic [3:0]          db_rodada,
    output logic [3:0]          db_contagem,
    output logic [3:0]          db_jogada,
    output logic [3:0]          db_memoria
);

    localparam int unsigned BitsBotao   = (N_BOTOES > 1) ? $clog2(N_BOTOES) : 1;
    localparam int unsigned BitsRodada  = $clog2(N_RODADAS);
    localparam int unsigned Profundidade = 1 << BitsRodada;
    // The LED timer also addresses memory while the sequence is generated.
    localparam int unsigned TimerMax    = (T_LED > N_RODADAS) ? T_LED : N_RODADAS;
    localparam int unsigned BitsTimer   = (TimerMax > 1) ? $clog2(TimerMax) : 1;
    localparam int unsigned BitsTimeout = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [LfsrWidth-1:0]   lfsr_q;
    logic                   botao_ant_q;
    logic [2:0]             jogada_idx_q;
    logic                   jogada_ok_q;
    logic [BitsBotao-1:0]   memoria_q [Profundidade];
    logic [BitsBotao-1:0]   elemento_atual;
    logic [BitsRodada-1:0]  rodada_q;
    logic [BitsRodada-1:0]  contagem_q;
    logic [BitsTimer-1:0]   timer_q;
    logic [BitsTimeout-1:0] timeout_q;

    // Free-running Fibonacci LFSR, reloaded with the seed on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SEMENTE;
        end else begin
            lfsr_q <= {lfsr_q[LfsrWidth-2:0], ^(lfsr_q & LfsrTaps)};
        end
    end

    // Previous-cycle button OR for edge detect; jogada captured in the edge cycle
    // so a one-cycle press is not lost before the compare.
    always_ff @(posedge clock) begin
        if (reset) begin
            botao_ant_q  <= 1'b0;
            jogada_idx_q <= '0;
            jogada_ok_q  <= 1'b0;
        end else begin
            botao_ant_q <= |botoes;
            if (grava_jogada) begin
                jogada_idx_q <= onehot_idx(8'(botoes));
                jogada_ok_q  <= is_onehot(8'(botoes));
            end
        end
    end

    // Sequence memory, one element written per preparation cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < Profundidade; i++) memoria_q[i] <= '0;
        end else if (grava_mem) begin
            memoria_q[timer_q[BitsRodada-1:0]] <= lfsr_q[BitsBotao-1:0];
        end
    end

    contador_param #(.Largura(BitsRodada), .Maximo(N_RODADAS - 1)) u_rodada (
        .clock (clock),
        .reset (reset),
        .zera  (zera_rodada),
        .conta (conta_rodada),
        .q     (rodada_q)
    );

    contador_param #(.Largura(BitsRodada), .Maximo(N_RODADAS - 1)) u_contagem (
        .clock (clock),
        .reset (reset),
        .zera  (zera_contagem),
        .conta (conta_contagem),
        .q     (contagem_q)
    );

    contador_param #(.Largura(BitsTimer), .Maximo(TimerMax - 1)) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timer),
        .conta (conta_timer),
        .q     (timer_q)
    );

    contador_param #(.Largura(BitsTimeout), .Maximo(TIMEOUT_CICLOS - 1)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timeout),
        .conta (conta_timeout),
        .q     (timeout_q)
    );

    assign elemento_atual     = memoria_q[contagem_q];
    assign jogada_edge        = (|botoes) & ~botao_ant_q;
    assign igual              = jogada_ok_q && (jogada_idx_q == 3'(elemento_atual));
    assign contagem_eq_rodada = (contagem_q == rodada_q);
    assign ultima_rodada      = (rodada_q == BitsRodada'(N_RODADAS - 1));
    assign fim_prep           = (timer_q == BitsTimer'(N_RODADAS - 1));
    assign fim_led            = (timer_q == BitsTimer'(T_LED - 1));
    assign fim_timeout        = (timeout_q == BitsTimeout'(TIMEOUT_CICLOS - 1));
    assign leds               = mostra ? N_BOTOES'(idx_onehot(3'(elemento_atual))) : '0;
    assign db_rodada          = 4'(rodada_q);
    assign db_contagem        = 4'(contagem_q);
    assign db_jogada          = {1'b0, jogada_idx_q};
    assign db_memoria         = 4'(elemento_atual);

endmodule

// File: rtl/unidade_controle_param.sv
// Game control FSM: preparation, optional demonstration, play, and end states.
module unidade_controle_param
    import jogo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       modo,
    input  logic       jogada_edge,
    input  logic       igual,
    input  logic       contagem_eq_rodada,
    input  logic       ultima_rodada,
    input  logic       fim_prep,
    input  logic       fim_led,
    input  logic       fim_timeout,
    output logic       grava_mem,
    output logic       zera_rodada,
    output logic       conta_rodada,
    output logic       zera_contagem,
    output logic       conta_contagem,
    output logic       zera_timer,
    output logic       conta_timer,
    output logic       zera_timeout,
    output logic       conta_timeout,
    output logic       grava_jogada,
    output logic       mostra,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado_q, estado_d;
    logic    modo_q;
    logic    carrega_modo;

    // State register and the modo value latched when a game starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= StInicial;
            modo_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            if (carrega_modo) modo_q <= modo;
        end
    end

    // Next state and control strobes; timers are held clear unless in use.
    always_comb begin
        estado_d       = estado_q;
        carrega_modo   = 1'b0;
        grava_mem      = 1'b0;
        zera_rodada    = 1'b0;
        conta_rodada   = 1'b0;
        zera_contagem  = 1'b0;
        conta_contagem = 1'b0;
        zera_timer     = 1'b1;
        conta_timer    = 1'b0;
        zera_timeout   = 1'b1;
        conta_timeout  = 1'b0;
        grava_jogada   = 1'b0;
        mostra         = 1'b0;
        pronto         = 1'b0;
        ganhou         = 1'b0;
        perdeu         = 1'b0;
        timeout        = 1'b0;
        case (estado_q)
            StInicial: begin
                if (iniciar) begin
                    carrega_modo = 1'b1;
                    estado_d     = StPreparacao;
                end
            end
            StPreparacao: begin
                grava_mem     = 1'b1;
                zera_rodada   = 1'b1;
                zera_contagem = 1'b1;
                conta_timer   = 1'b1;
                zera_timer    = fim_prep;
                if (fim_prep) estado_d = modo_q ? StMostraLed : StEsperaJogada;
            end
            StMostraLed: begin
                mostra      = 1'b1;
                conta_timer = 1'b1;
                zera_timer  = fim_led;
                if (fim_led) estado_d = StApagaLed;
            end
            StApagaLed: begin
                conta_timer = 1'b1;
                zera_timer  = fim_led;
                if (fim_led) begin
                    if (contagem_eq_rodada) begin
                        zera_contagem = 1'b1;
                        estado_d      = StEsperaJogada;
                    end else begin
                        conta_contagem = 1'b1;
                        estado_d       = StMostraLed;
                    end
                end
            end
            StEsperaJogada: begin
                conta_timeout = 1'b1;
                zera_timeout  = jogada_edge;
                // A jogada on the expiry cycle takes precedence over the timeout.
                if (jogada_edge) begin
                    grava_jogada = 1'b1;
                    estado_d     = StRegistra;
                end else if (fim_timeout) begin
                    estado_d = StFimTimeout;
                end
            end
            StRegistra: begin
                estado_d = StCompara;
            end
            StCompara: begin
                if (!igual) begin
                    estado_d = StFimErro;
                end else if (!contagem_eq_rodada) begin
                    conta_contagem = 1'b1;
                    estado_d       = StEsperaJogada;
                end else begin
                    estado_d = StUltimaRodada;
                end
            end
            StUltimaRodada: begin
                if (ultima_rodada) begin
                    estado_d = StFimAcerto;
                end else begin
                    conta_rodada  = 1'b1;
                    zera_contagem = 1'b1;
                    estado_d      = modo_q ? StMostraLed : StEsperaJogada;
                end
            end
            StFimAcerto, StFimErro, StFimTimeout: begin
                pronto  = 1'b1;
                ganhou  = (estado_q == StFimAcerto);
                perdeu  = (estado_q != StFimAcerto);
                timeout = (estado_q == StFimTimeout);
                if (iniciar) begin
                    carrega_modo = 1'b1;
                    estado_d     = StPreparacao;
                end
            end
            default: begin
                estado_d = StInicial;
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: rtl/jogo_sequencia_param.sv
// Parametrised memory-sequence game engine: control FSM plus datapath.
module jogo_sequencia_param #(
    parameter int unsigned N_BOTOES       = 4,
    parameter int unsigned N_RODADAS      = 16,
    parameter int unsigned TIMEOUT_CICLOS = 3000,
    parameter int unsigned T_LED          = 1000,
    parameter logic [7:0]  SEMENTE        = 8'hA5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                modo,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic [3:0]          db_rodada,
    output logic [3:0]          db_contagem,
    output logic [3:0]          db_jogada,
    output logic [3:0]          db_memoria,
    output logic [3:0]          db_estado
);

    logic jogada_edge, igual, contagem_eq_rodada, ultima_rodada;
    logic fim_prep, fim_led, fim_timeout;
    logic grava_mem, zera_rodada, conta_rodada, zera_contagem, conta_contagem;
    logic zera_timer, conta_timer, zera_timeout, conta_timeout, grava_jogada, mostra;

    unidade_controle_param u_uc (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .modo               (modo),
        .jogada_edge        (jogada_edge),
        .igual              (igual),
        .contagem_eq_rodada (contagem_eq_rodada),
        .ultima_rodada      (ultima_rodada),
        .fim_prep           (fim_prep),
        .fim_led            (fim_led),
        .fim_timeout        (fim_timeout),
        .grava_mem          (grava_mem),
        .zera_rodada        (zera_rodada),
        .conta_rodada       (conta_rodada),
        .zera_contagem      (zera_contagem),
        .conta_contagem     (conta_contagem),
        .zera_timer         (zera_timer),
        .conta_timer        (conta_timer),
        .zera_timeout       (zera_timeout),
        .conta_timeout      (conta_timeout),
        .grava_jogada       (grava_jogada),
        .mostra             (mostra),
        .pronto             (pronto),
        .ganhou             (ganhou),
        .perdeu             (perdeu),
        .timeout            (timeout),
        .db_estado          (db_estado)
    );

    fluxo_dados_param #(
        .N_BOTOES       (N_BOTOES),
        .N_RODADAS      (N_RODADAS),
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .T_LED          (T_LED),
        .SEMENTE        (SEMENTE)
    ) u_fd (
        .clock              (clock),
        .reset              (reset),
        .botoes             (botoes),
        .grava_mem          (grava_mem),
        .zera_rodada        (zera_rodada),
        .conta_rodada       (conta_rodada),
        .zera_contagem      (zera_contagem),
        .conta_contagem     (conta_contagem),
        .zera_timer         (zera_timer),
        .conta_timer        (conta_timer),
        .zera_timeout       (zera_timeout),
        .conta_timeout      (conta_timeout),
        .grava_jogada       (grava_jogada),
        .mostra             (mostra),
        .jogada_edge        (jogada_edge),
        .igual              (igual),
        .contagem_eq_rodada (contagem_eq_rodada),
        .ultima_rodada      (ultima_rodada),
        .fim_prep           (fim_prep),
        .fim_led            (fim_led),
        .fim_timeout        (fim_timeout),
        .leds               (leds),
        .db_rodada          (db_rodada),
        .db_contagem        (db_contagem),
        .db_jogada          (db_jogada),
        .db_memoria         (db_memoria)
    );

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Directed testbench for jogo_sequencia_param (4 buttons, 4 rounds, timeout 20, T_LED 3).
module tb_jogo_sequencia_param;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       iniciar = 1'b0;
    logic       modo    = 1'b0;
    logic [3:0] botoes  = '0;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu, timeout;
    logic [3:0] db_rodada, db_contagem, db_jogada, db_memoria, db_estado;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_lfsr;
    logic [1:0] seq [4];

    jogo_sequencia_param #(
        .N_BOTOES       (4),
        .N_RODADAS      (4),
        .TIMEOUT_CICLOS (20),
        .T_LED          (3),
        .SEMENTE        (8'hA5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .modo        (modo),
        .botoes      (botoes),
        .leds        (leds),
        .pronto      (pronto),
        .ganhou      (ganhou),
        .perdeu      (perdeu),
        .timeout     (timeout),
        .db_rodada   (db_rodada),
        .db_contagem (db_contagem),
        .db_jogada   (db_jogada),
        .db_memoria  (db_memoria),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, seed on reset.
    always @(posedge clock) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start a game and record the four elements written during preparation.
    task automatic start_game(input logic m);
        iniciar = 1'b1;
        modo    = m;
        tick();
        iniciar = 1'b0;
        modo    = ~m;
        for (int k = 0; k < 4; k++) begin
            seq[k] = m_lfsr[1:0];
            if (k < 3) tick();
        end
        tick();
    endtask

    // Press for one cycle, then advance through registra and compara.
    task automatic press(input logic [3:0] b);
        botoes = b;
        tick();
        botoes = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (db_estado !== 4'h0) begin failures++; $display("FAIL reset_state: got %h expected 0", db_estado); end
        checks++; if (leds !== 4'h0) begin failures++; $display("FAIL reset_leds: got %b expected 0000", leds); end
        checks++; if ({pronto, ganhou, perdeu, timeout} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b expected 0000", {pronto, ganhou, perdeu, timeout}); end
        checks++; if ({db_rodada, db_contagem, db_jogada} !== 12'h000) begin failures++; $display("FAIL reset_counters: got %h expected 000", {db_rodada, db_contagem, db_jogada}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_win();
        start_game(1'b0);
        checks++; if (db_estado !== 4'h4) begin failures++; $display("FAIL win_start: got %h expected 4", db_estado); end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c <= r; c++) begin
                press(oh(seq[c]));
                checks++; if (db_jogada !== {2'b00, seq[c]}) begin failures++; $display("FAIL win_jogada r=%0d c=%0d: got %h expected %h", r, c, db_jogada, seq[c]); end
                if (c < r) begin
                    checks++; if (db_estado !== 4'h4) begin failures++; $display("FAIL win_next r=%0d c=%0d: got %h expected 4", r, c, db_estado); end
                end else begin
                    checks++; if (db_estado !== 4'h7) begin failures++; $display("FAIL win_ultima r=%0d: got %h expected 7", r, db_estado); end
                    tick();
                    checks++; if (db_estado !== ((r < 3) ? 4'h4 : 4'hC)) begin failures++; $display("FAIL win_round_end r=%0d: got %h", r, db_estado); end
                end
            end
        end
        checks++; if ({pronto, ganhou, perdeu, timeout} !== 4'b1100) begin failures++; $display("FAIL win_flags: got %b expected 1100", {pronto, ganhou, perdeu, timeout}); end
        checks++; if (db_rodada !== 4'd3) begin failures++; $display("FAIL win_rodada: got %0d expected 3", db_rodada); end
        repeat (5) tick();
        checks++; if ({db_estado, ganhou, pronto} !== 6'b1100_11) begin failures++; $display("FAIL win_hold: got %h/%b%b expected C/11", db_estado, ganhou, pronto); end
    endtask

    task automatic test_wrong_jogada();
        start_game(1'b0);
        press(oh(seq[0]));
        tick();
        checks++; if (db_rodada !== 4'd1) begin failures++; $display("FAIL wrong_round1: got %0d expected 1", db_rodada); end
        press(oh(seq[0]));
        checks++; if (db_contagem !== 4'd1) begin failures++; $display("FAIL wrong_contagem: got %0d expected 1", db_contagem); end
        press(oh(seq[1] + 2'd1));
        checks++; if (db_estado !== 4'hE) begin failures++; $display("FAIL wrong_state: got %h expected E", db_estado); end
        checks++; if ({pronto, ganhou, perdeu, timeout} !== 4'b1010) begin failures++; $display("FAIL wrong_flags: got %b expected 1010", {pronto, ganhou, perdeu, timeout}); end
    endtask

    task automatic test_timeout();
        start_game(1'b0);
        repeat (19) tick();
        checks++; if (db_estado !== 4'h4) begin failures++; $display("FAIL timeout_early: got %h expected 4", db_estado); end
        tick();
        checks++; if (db_estado !== 4'hD) begin failures++; $display("FAIL timeout_state: got %h expected D", db_estado); end
        checks++; if ({pronto, ganhou, perdeu, timeout} !== 4'b1011) begin failures++; $display("FAIL timeout_flags: got %b expected 1011", {pronto, ganhou, perdeu, timeout}); end
    endtask

    task automatic test_invalid_press();
        start_game(1'b0);
        press(4'b0011);
        checks++; if (db_estado !== 4'hE) begin failures++; $display("FAIL invalid_state: got %h expected E", db_estado); end
        // Hold the correct button for 10 cycles: only the rising edge counts.
        start_game(1'b0);
        botoes = oh(seq[0]);
        repeat (10) tick();
        checks++; if ({db_estado, db_rodada, db_contagem} !== 12'h410) begin failures++; $display("FAIL hold_single: got %h expected 410", {db_estado, db_rodada, db_contagem}); end
        botoes = '0;
        tick();
        press(oh(seq[0]));
        checks++; if ({db_estado, db_contagem} !== 8'h41) begin failures++; $display("FAIL hold_next: got %h expected 41", {db_estado, db_contagem}); end
        repeat (20) tick();
        checks++; if (db_estado !== 4'hD) begin failures++; $display("FAIL hold_timeout: got %h expected D", db_estado); end
    endtask

    task automatic test_demonstration();
        start_game(1'b1);
        checks++; if (db_estado !== 4'h2) begin failures++; $display("FAIL demo_start: got %h expected 2", db_estado); end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c <= r; c++) begin
                for (int t = 0; t < 3; t++) begin
                    checks++; if (leds !== oh(seq[c])) begin failures++; $display("FAIL demo_on r=%0d c=%0d t=%0d: got %b expected %b", r, c, t, leds, oh(seq[c])); end
                    tick();
                end
                for (int t = 0; t < 3; t++) begin
                    checks++; if (leds !== 4'b0000) begin failures++; $display("FAIL demo_off r=%0d c=%0d t=%0d: got %b expected 0000", r, c, t, leds); end
                    tick();
                end
            end
            checks++; if ({db_estado, leds} !== 8'h40) begin failures++; $display("FAIL demo_after r=%0d: got %h expected 40", r, {db_estado, leds}); end
            for (int c = 0; c <= r; c++) press(oh(seq[c]));
            tick();
            checks++; if (db_estado !== 4'h2) begin failures++; $display("FAIL demo_next r=%0d: got %h expected 2", r, db_estado); end
        end
    endtask

    task automatic test_reset_mid_demo();
        tick();
        checks++; if (leds !== oh(seq[0])) begin failures++; $display("FAIL middemo_leds: got %b expected %b", leds, oh(seq[0])); end
        reset = 1'b1;
        tick();
        checks++; if ({db_estado, leds} !== 8'h00) begin failures++; $display("FAIL middemo_reset: got %h expected 00", {db_estado, leds}); end
        checks++; if ({pronto, ganhou, perdeu, timeout} !== 4'b0000) begin failures++; $display("FAIL middemo_flags: got %b expected 0000", {pronto, ganhou, perdeu, timeout}); end
        checks++; if ({db_rodada, db_contagem, db_jogada} !== 12'h000) begin failures++; $display("FAIL middemo_counters: got %h expected 000", {db_rodada, db_contagem, db_jogada}); end
        reset = 1'b0;
        tick();
        start_game(1'b0);
        checks++; if ({db_estado, db_memoria} !== {4'h4, 2'b00, seq[0]}) begin failures++; $display("FAIL regen_mem0: got %h expected 4%h", {db_estado, db_memoria}, seq[0]); end
        press(oh(seq[0]));
        tick();
        press(oh(seq[0]));
        checks++; if ({db_estado, db_memoria} !== {4'h4, 2'b00, seq[1]}) begin failures++; $display("FAIL regen_mem1: got %h expected 4%h", {db_estado, db_memoria}, seq[1]); end
    endtask

    initial begin
        test_reset();
        test_win();
        test_wrong_jogada();
        test_timeout();
        test_invalid_press();
        test_demonstration();
        test_reset_mid_demo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
